// File: rtl/ram_write_arbiter_if.sv
// Signal bundle for ram_write_arbiter: requesters A/B, clear control and the RAM write port.
// The arbiter uses the slave modport; the side that drives requests and the clear uses master.
interface ram_write_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12
);
  logic                  a_req;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_gnt;

  logic                  b_req;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_gnt;

  logic                  clr_start;
  logic [DATA_WIDTH-1:0] clr_data;
  logic                  clr_busy;
  logic                  clr_done;

  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_write_en;

  modport master (
    output a_req, a_addr, a_data, b_req, b_addr, b_data, clr_start, clr_data,
    input  a_gnt, b_gnt, clr_busy, clr_done, ram_waddr, ram_din, ram_write_en
  );

  modport slave (
    input  a_req, a_addr, a_data, b_req, b_addr, b_data, clr_start, clr_data,
    output a_gnt, b_gnt, clr_busy, clr_done, ram_waddr, ram_din, ram_write_en
  );
endinterface

// File: rtl/ram_write_arbiter.sv
// Round-robin write arbiter for two requesters onto one RAM write port, with an optional
// full-RAM clear sweep compiled in when RAM_WRITE_ARBITER_CLEAR_EN is defined.
module ram_write_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_write_arbiter_if.slave    bus
);

  logic                  r_rr_b;   // 1: B wins the next contended arbitration
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_we;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_clr_go;
  logic                  w_in_clear;
  logic                  w_clr_last;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic [DATA_WIDTH-1:0] w_clr_data;
  logic                  w_a_gnt;
  logic                  w_b_gnt;
  logic                  w_contended;

`ifdef RAM_WRITE_ARBITER_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_clr_fill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    // NOTE: registers take <= so every flop samples pre-edge values regardless of block order.
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves the signal unassigned and infers a latch.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.clr_start)      w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_clr_cnt == '1)    w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_clear = (r_state == ST_CLEAR);
    w_clr_go   = (r_state == ST_IDLE) && bus.clr_start;
    w_clr_last = (r_state == ST_CLEAR) && (r_clr_cnt == '1);
  end

  // Counter wrap after the all-ones address is harmless: the FSM has already left CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_cnt  <= '0;
      r_clr_fill <= '0;
    end else if (w_clr_go) begin
      r_clr_cnt  <= '0;
      r_clr_fill <= bus.clr_data;
    end else if (w_in_clear) begin
      r_clr_cnt  <= r_clr_cnt + 1'b1;
    end
  end

  assign w_clr_addr = r_clr_cnt;
  assign w_clr_data = r_clr_fill;
`else
  logic w_unused_clr;

  assign w_unused_clr = ^{bus.clr_start, bus.clr_data};
  assign w_in_clear   = 1'b0;
  assign w_clr_go     = 1'b0;
  assign w_clr_last   = 1'b0;
  assign w_clr_addr   = '0;
  assign w_clr_data   = '0;
`endif

  // Grants are combinational; a clear (running or starting) and reset both block them.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (!reset && !w_in_clear && !w_clr_go) begin
      if (bus.a_req && (!bus.b_req || !r_rr_b)) w_a_gnt = 1'b1;
      else if (bus.b_req)                       w_b_gnt = 1'b1;
    end
  end

  assign w_contended = bus.a_req && bus.b_req && (w_a_gnt || w_b_gnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_b  <= 1'b0;
      r_waddr <= '0;
      r_din   <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we   <= w_in_clear || w_a_gnt || w_b_gnt;
      r_busy <= w_in_clear;
      r_done <= w_clr_last;
      if (w_contended) r_rr_b <= w_a_gnt;
      if (w_in_clear) begin
        r_waddr <= w_clr_addr;
        r_din   <= w_clr_data;
      end else if (w_a_gnt) begin
        r_waddr <= bus.a_addr;
        r_din   <= bus.a_data;
      end else if (w_b_gnt) begin
        r_waddr <= bus.b_addr;
        r_din   <= bus.b_data;
      end
    end
  end

  assign bus.a_gnt        = w_a_gnt;
  assign bus.b_gnt        = w_b_gnt;
  assign bus.ram_waddr    = r_waddr;
  assign bus.ram_din      = r_din;
  assign bus.ram_write_en = r_we;
  assign bus.clr_busy     = r_busy;
  assign bus.clr_done     = r_done;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Self-checking bench for ram_write_arbiter: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model and a RAM image.
`timescale 1ns/1ps
module tb_ram_write_arbiter;
  localparam int AW    = 8;
  localparam int DW    = 12;
  localparam int DEPTH = 1 << AW;
`ifdef RAM_WRITE_ARBITER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  ram_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM fed by the DUT outputs, and the image the model says it must hold.
  logic [DW-1:0] ram   [DEPTH] = '{default: '0};
  logic [DW-1:0] m_ram [DEPTH] = '{default: '0};

  always @(posedge clk) if (bus.ram_write_en) ram[bus.ram_waddr] <= bus.ram_din;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who should win, how many clear writes remain, what the port shows.
  bit            m_favour_b;
  int            m_clr_left;
  logic [DW-1:0] m_fill;
  logic          e_we, e_busy, e_done;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_din;
  bit            a_xfer, b_xfer;

  always @(negedge clk) begin : model
    bit clr_act, start, ga, gb;
    clr_act = 1'b0; start = 1'b0; ga = 1'b0; gb = 1'b0;
    if (rst) begin
      m_favour_b = 1'b0;
      m_clr_left = 0;
      e_we = 1'b0; e_waddr = '0; e_din = '0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      clr_act = (m_clr_left > 0);
      start   = CLEAR_EN && !clr_act && bus.clr_start;
      if (clr_act || start) begin
        ga = 1'b0; gb = 1'b0;
      end else if (bus.a_req && bus.b_req) begin
        ga = !m_favour_b; gb = m_favour_b;
      end else begin
        ga = bus.a_req; gb = bus.b_req;
      end
    end
    check("a_gnt",        bus.a_gnt,        ga);
    check("b_gnt",        bus.b_gnt,        gb);
    check("ram_write_en", bus.ram_write_en, e_we);
    check("ram_waddr",    bus.ram_waddr,    e_waddr);
    check("ram_din",      bus.ram_din,      e_din);
    check("clr_busy",     bus.clr_busy,     e_busy);
    check("clr_done",     bus.clr_done,     e_done);
    a_xfer = bus.a_req && ga;
    b_xfer = bus.b_req && gb;
    if (!rst) begin
      if (e_we) m_ram[e_waddr] = e_din;
      if (clr_act) begin
        e_we    = 1'b1;
        e_waddr = AW'(DEPTH - m_clr_left);
        e_din   = m_fill;
        e_busy  = 1'b1;
        e_done  = (m_clr_left == 1);
        m_clr_left--;
      end else begin
        e_busy = 1'b0;
        e_done = 1'b0;
        e_we   = ga || gb;
        if (ga) begin
          e_waddr = bus.a_addr; e_din = bus.a_data;
        end else if (gb) begin
          e_waddr = bus.b_addr; e_din = bus.b_data;
        end
        if (bus.a_req && bus.b_req && (ga || gb)) m_favour_b = ga;
        if (start) begin
          m_clr_left = DEPTH;
          m_fill     = bus.clr_data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.a_req = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_req = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.clr_start = 1'b0; bus.clr_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    drive_idle();
    repeat (3) tick();
    check("rst_we",    bus.ram_write_en, 0);
    check("rst_waddr", bus.ram_waddr,    0);
    check("rst_din",   bus.ram_din,      0);
    check("rst_busy",  bus.clr_busy,     0);
    check("rst_done",  bus.clr_done,     0);
    rst = 1'b0;

    // Single requester
    bus.a_req = 1'b1; bus.a_addr = 8'h05; bus.a_data = 12'hABC;
    #3 check("single_gnt", bus.a_gnt, 1);
    tick();
    bus.a_req = 1'b0;
    check("single_we",    bus.ram_write_en, 1);
    check("single_waddr", bus.ram_waddr,    8'h05);
    check("single_din",   bus.ram_din,      12'hABC);
    tick();
    check("single_ram", ram[8'h05], 12'hABC);

    // Contention right after reset: A, B, A, B
    do_reset();
    bus.a_req = 1'b1; bus.a_addr = 8'h10; bus.a_data = 12'h111;
    bus.b_req = 1'b1; bus.b_addr = 8'h20; bus.b_data = 12'h222;
    for (int i = 0; i < 4; i++) begin
      #3 check("cont_gnt", {bus.a_gnt, bus.b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      check("cont_waddr", bus.ram_waddr, (i % 2 == 0) ? 8'h10 : 8'h20);
    end
    drive_idle();

`ifdef RAM_WRITE_ARBITER_CLEAR_EN
    // Clear with A requesting from the same cycle
    do_reset();
    bus.clr_start = 1'b1; bus.clr_data = 12'h0F0;
    bus.a_req = 1'b1; bus.a_addr = 8'h33; bus.a_data = 12'h555;
    #3 check("clr_start_gnt", bus.a_gnt, 0);
    begin
      int writes, busy_cyc, done_cnt, bad_wr, early;
      bit granted, gnt_in_done, a_checked, a_landed;
      writes = 0; busy_cyc = 0; done_cnt = 0; bad_wr = 0; early = 0;
      granted = 0; gnt_in_done = 0; a_checked = 0; a_landed = 0;
      for (int c = 0; c < 300; c++) begin
        tick();
        bus.clr_start = 1'b0;
        if (granted && !a_checked) begin
          a_checked = 1;
          a_landed  = bus.ram_write_en && !bus.clr_busy &&
                      (bus.ram_waddr == 8'h33) && (bus.ram_din == 12'h555);
          bus.a_req = 1'b0;
        end
        if (bus.clr_busy && bus.ram_write_en) begin
          if (bus.ram_waddr != AW'(writes) || bus.ram_din != 12'h0F0) bad_wr++;
          writes++;
        end
        busy_cyc += int'(bus.clr_busy);
        done_cnt += int'(bus.clr_done);
        #3;
        if (bus.a_gnt && bus.clr_busy && !bus.clr_done) early++;
        if (bus.a_gnt && !granted) begin
          granted     = 1;
          gnt_in_done = bus.clr_done;
        end
      end
      check("clr_writes",      writes,      256);
      check("clr_busy_cycles", busy_cyc,    256);
      check("clr_done_pulses", done_cnt,    1);
      check("clr_bad_writes",  bad_wr,      0);
      check("clr_early_gnt",   early,       0);
      check("clr_gnt_in_done", gnt_in_done, 1);
      check("clr_a_landed",    a_landed,    1);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== ((i == 8'h33) ? 12'h555 : 12'h0F0)) bad++;
    check("clr_ram_bad", bad, 0);

    // Reset in the middle of a clear, at sweep address 0x40
    tick();
    bus.clr_start = 1'b1; bus.clr_data = 12'h777;
    begin
      bit found;
      int done_cnt, wr;
      found = 0;
      for (int c = 0; c < 300 && !found; c++) begin
        tick();
        bus.clr_start = 1'b0;
        if (bus.ram_write_en && bus.clr_busy && bus.ram_waddr == 8'h40) found = 1;
      end
      check("mid_found", found, 1);
      rst = 1'b1;
      bus.a_req = 1'b1;
      #1;
      check("mid_rst_we",    bus.ram_write_en, 0);
      check("mid_rst_waddr", bus.ram_waddr,    0);
      check("mid_rst_din",   bus.ram_din,      0);
      check("mid_rst_busy",  bus.clr_busy,     0);
      check("mid_rst_gnt",   {bus.a_gnt, bus.b_gnt}, 0);
      tick();
      tick();
      rst = 1'b0;
      bus.a_req = 1'b0;
      done_cnt = 0; wr = 0;
      for (int c = 0; c < 300; c++) begin
        tick();
        done_cnt += int'(bus.clr_done);
        wr       += int'(bus.ram_write_en);
      end
      check("mid_done_never", done_cnt, 0);
      check("mid_no_writes",  wr,       0);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== ((i < 8'h40) ? 12'h777 : 12'h0F0)) bad++;
    check("mid_ram_bad", bad, 0);
`else
    // Clear engine absent: clr_start is ignored and A is granted at once
    do_reset();
    bus.clr_start = 1'b1; bus.clr_data = 12'hFFF;
    bus.a_req = 1'b1; bus.a_addr = 8'h44; bus.a_data = 12'h123;
    #3 check("nc_gnt", bus.a_gnt, 1);
    tick();
    bus.clr_start = 1'b0;
    bus.a_req     = 1'b0;
    check("nc_we",    bus.ram_write_en, 1);
    check("nc_waddr", bus.ram_waddr,    8'h44);
    check("nc_busy",  bus.clr_busy,     0);
    begin
      int wr, flags;
      wr = 0; flags = 0;
      for (int c = 0; c < 300; c++) begin
        bus.clr_start = (c % 50 == 0);
        tick();
        wr    += int'(bus.ram_write_en);
        flags += int'(bus.clr_busy) + int'(bus.clr_done);
      end
      check("nc_no_writes", wr,    0);
      check("nc_no_flags",  flags, 0);
    end
`endif

    // Randomized traffic; requesters hold until granted
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (a_xfer || !bus.a_req) begin
        bus.a_req  = ($urandom_range(0, 99) < 55);
        bus.a_addr = AW'($urandom);
        bus.a_data = DW'($urandom);
      end
      if (b_xfer || !bus.b_req) begin
        bus.b_req  = ($urandom_range(0, 99) < 55);
        bus.b_addr = AW'($urandom);
        bus.b_data = DW'($urandom);
      end
      bus.clr_start = ($urandom_range(0, 399) == 0);
      bus.clr_data  = DW'($urandom);
      tick();
    end
    drive_idle();
    repeat (300) tick();

    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== m_ram[i]) bad++;
    check("final_ram_image", bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
